// File: rtl/mem_bus_arbiter.sv
// Two-port request/grant arbiter sharing the CPU memory bus between the CPU (port 0)
// and the boot-loader/DMA engine (port 1). Optional port-1 bus lock: MEM_ARB_LOCK_EN.
module mem_bus_arbiter #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned PRIO         = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_req0,
  input  logic [31:0] in_addr0,
  input  logic        in_we0,
  input  logic [31:0] in_wdata0,
  input  logic        in_req1,
  input  logic [31:0] in_addr1,
  input  logic        in_we1,
  input  logic [31:0] in_wdata1,
`ifdef MEM_ARB_LOCK_EN
  input  logic        in_lock1,
`endif
  output logic        out_gnt0,
  output logic        out_gnt1,
  output logic [31:0] out_rdata0,
  output logic [31:0] out_rdata1,
  output logic        out_rvalid0,
  output logic        out_rvalid1,
  output logic [31:0] out_mem_address,
  output logic        out_mem_write_en,
  output logic [31:0] out_mem_write_data,
  input  logic [31:0] in_mem_read_data
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

  logic        owner;
  logic [7:0]  burst_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  rd_tag_t     pipe [READ_LATENCY];

  logic        burst_full;
  logic        lock_active;
  logic        gnt0;
  logic        gnt1;
  logic        any_gnt;
  logic        gnt_port;
  logic        gnt_we;

  assign burst_full = (burst_cnt >= MAX_B);

`ifdef MEM_ARB_LOCK_EN
  logic lock_q;

  // The lock only holds while in_lock1 stays high, so port 0 regains eligibility
  // in the very cycle the boot loader drops it.
  assign lock_active = lock_q & in_lock1;

  always_ff @(posedge clk) begin
    if (!reset) lock_q <= 1'b0;
    else        lock_q <= in_lock1 & (lock_q | gnt1);
  end
`else
  assign lock_active = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (lock_active) begin
      gnt1 = in_req1;
    end else if (in_req0 && in_req1) begin
      // Stay with the owner until its burst budget is spent, then hand over.
      if (burst_full ^ owner) gnt1 = 1'b1;
      else                    gnt0 = 1'b1;
    end else begin
      gnt0 = in_req0;
      gnt1 = in_req1;
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign gnt_port = gnt1;
  assign gnt_we   = (gnt0 & in_we0) | (gnt1 & in_we1);

  always_comb begin
    out_mem_address    = addr_q;
    out_mem_write_data = wdata_q;
    out_mem_write_en   = 1'b0;
    if (!reset) begin
      out_mem_address    = '0;
      out_mem_write_data = '0;
    end else if (gnt0) begin
      out_mem_address    = in_addr0;
      out_mem_write_data = in_wdata0;
      out_mem_write_en   = in_we0;
    end else if (gnt1) begin
      out_mem_address    = in_addr1;
      out_mem_write_data = in_wdata1;
      out_mem_write_en   = in_we1;
    end
  end

  assign out_gnt0 = gnt0;
  assign out_gnt1 = gnt1;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner     <= 1'(PRIO);
      burst_cnt <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else if (any_gnt) begin
      addr_q  <= out_mem_address;
      wdata_q <= out_mem_write_data;
      if (gnt_port == owner) begin
        burst_cnt <= burst_full ? MAX_B : 8'(burst_cnt + 8'd1);
      end else begin
        owner     <= gnt_port;
        burst_cnt <= 8'd1;
      end
    end else begin
      burst_cnt <= '0;
    end
  end

  // Return-tag pipeline: one slot per cycle of memory read latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the tag pipeline is reset (not just its head) so reads in flight
      // at reset can never surface as a stray rvalid afterwards.
      for (int i = 0; i < int'(READ_LATENCY); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: any_gnt & ~gnt_we, port: gnt_port};
      for (int i = 1; i < int'(READ_LATENCY); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign out_rvalid0 = pipe[READ_LATENCY-1].valid & ~pipe[READ_LATENCY-1].port;
  assign out_rvalid1 = pipe[READ_LATENCY-1].valid &  pipe[READ_LATENCY-1].port;
  assign out_rdata0  = in_mem_read_data;
  assign out_rdata1  = in_mem_read_data;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-port arbiter that shares the CPU-side memory bus (the memory mapper input: address, write data, write enable, read data) between the CPU (port 0) and a UART boot-loader/DMA engine (port 1). Transfers are per-cycle request/grant. Contention is resolved by owner-stickiness with a bounded burst length. Read data is routed back to the originating port after a fixed memory read latency.

Parameters:
READ_LATENCY, 1, cycles from grant edge to valid read data on in_mem_read_data (1..4)
MAX_BURST, 16, max consecutive grants to the current owner while the other port is requesting (1..255)
PRIO, 0, port that owns the bus after reset (0 or 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
in_req0 / in_req1  input  1  transfer request, held until granted
in_addr0 / in_addr1  input  32  byte address
in_we0 / in_we1  input  1  1 = write, 0 = read
in_wdata0 / in_wdata1  input  32  write data
out_gnt0 / out_gnt1  output  1  combinational grant; transfer occurs in any cycle with req&gnt
out_rdata0 / out_rdata1  output  32  read data (shared copy of in_mem_read_data)
out_rvalid0 / out_rvalid1  output  1  one-cycle pulse when read data is valid for that port
out_mem_address  output  32  to memory mapper
out_mem_write_en  output  1  to memory mapper
out_mem_write_data  output  32  to memory mapper
in_mem_read_data  input  32  from memory mapper

Behaviour:
- Reset: sampled on posedge clk while reset==0.
  - Effects: owner<=PRIO, burst_cnt<=0, rvalid/tag pipeline cleared.
  - While reset==0: out_gnt0/1=0, out_mem_write_en=0, out_mem_address=0, out_mem_write_data=0.
  - out_rvalid0/1=0 from the first edge with reset low.
- Grant logic (combinational from req, owner, burst_cnt):
  - No request: no grant.
  - Only one port requesting: grant it.
  - Both requesting:
    - burst_cnt < MAX_BURST: grant owner.
    - Otherwise: grant the other port.
  - At most one grant per cycle.
- Downstream mux (combinational):
  - Granted port's addr/wdata drive out_mem_address/out_mem_write_data.
  - out_mem_write_en = granted port's we.
  - No grant: write_en=0; address and data hold their last registered granted values.
- Registered state on posedge:
  - Grant to the owner: burst_cnt <= min(burst_cnt+1, MAX_BURST).
  - Grant to the non-owner: owner <= that port, burst_cnt <= 1.
  - Cycle with no grant: burst_cnt <= 0, owner unchanged.
- Read return:
  - Each granted read pushes {valid=1, port} into a READ_LATENCY-deep shift pipeline.
  - At the pipeline output, out_rvalidN is asserted for exactly one cycle on the tagged port.
  - Writes push valid=0, so no rvalid is produced for a write.
  - Back-to-back reads from either or both ports are fully pipelined: one return per cycle, in grant order.
- out_rdata0/1 are always equal to in_mem_read_data; consumers qualify with rvalid.
- Port switching does not drain the pipeline; in-flight returns still route to their original port.
- Reset mid-operation: all in-flight reads are discarded and no rvalid follows. Requesters must re-issue.
- Requester contract: req, addr, we and wdata stable while req=1 and gnt=0. Deasserting req before grant is legal (request withdrawn).
- Simultaneous first requests from idle (burst_cnt=0): the owner wins. The owner is PRIO after reset.

Optional Feature:
MEM_ARB_LOCK_EN
- Defined:
  - Adds input port in_lock1 (1 bit).
  - A grant to port 1 with in_lock1=1 sets a lock flag.
  - While locked, port 0 is never granted, regardless of MAX_BURST.
  - The lock clears on the first cycle with in_lock1=0. Port 0 is eligible in that same cycle.
  - Reset clears the lock.
  - Used by the boot loader to write a program image atomically.
- Undefined: no in_lock1 port, no lock flag; arbitration is purely burst-based.

Test Plan:
1. Reset hold: reset=0 for 3 cycles with in_req0=in_req1=1 -> out_gnt0=out_gnt1=0, out_mem_write_en=0, out_mem_address=0, no rvalid.
2. Single read, READ_LATENCY=1: in_req0=1, addr=0x100, we=0; memory returns 0xDEADBEEF -> out_gnt0=1 in the same cycle, out_mem_address=0x100; next cycle out_rvalid0=1, out_rdata0=0xDEADBEEF, out_rvalid1=0.
3. Contention, MAX_BURST=4, PRIO=0: both reqs held high for 12 cycles -> grant sequence 0,0,0,0,1,1,1,1,0,0,0,0.
4. Write: in_req1=1, addr=0x20000040, wdata=0x12345678, we=1 -> out_gnt1=1, out_mem_write_en=1 for exactly 1 cycle with matching addr/data; no out_rvalid1.
5. Reset mid-read, READ_LATENCY=2: port 0 read granted, reset=0 on the following edge -> out_rvalid0 never pulses.
6. Lock (MEM_ARB_LOCK_EN): in_lock1=1 with port 1 requesting for 10 cycles and in_req0 pending -> 10 consecutive grants to port 1; lock1 drops -> port 0 granted in the next cycle.
